pe_link_rr_arbiter: RTL

//  Round-robin arbiter sharing one registered mesh link (e.g. out_to_east) of a PE tile

---
 rtl/pe_link_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pe_link_rr_arbiter.sv
// Burst-locked round-robin arbiter sharing one registered PE mesh link between NUM_REQ requesters.
// Define PE_ARB_STATS_EN to add per-requester grant counters on stat_grants.
module pe_link_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 130,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ap_start,
  input  logic [NUM_REQ-1:0]              in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_REQ-1:0]              in_last,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
`ifdef PE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]        stat_grants
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || MAX_BURST < 1 || CNT_W < 1) begin : g_param_check
    $error("pe_link_rr_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [BC_W-1:0]       cnt;
  logic                  can_load;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]    rot_valid;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat_last;

  assign can_load  = !out_valid || out_ready;
  assign beat_last = sel_last || (cnt == BC_W'(MAX_BURST - 1));

  // Rotate requests so bit 0 is the current priority holder, then take the first set bit.
  always_comb begin : arb_pick
    int unsigned sum;
    rot_valid  = NUM_REQ'({in_valid, in_valid} >> ptr);
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && rot_valid[i]) begin
        pick_found = 1'b1;
        sum        = 32'(ptr) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        pick_idx   = ID_W'(sum);
      end
    end
  end

  always_comb begin : grant_mux
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready[i] = (state == BURST) && can_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef PE_ARB_STATS_EN
      stat_grants <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Drain any beat left from the previous burst; nothing new loads here.
          if (out_ready) out_valid <= 1'b0;
          if (ap_start && pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= BURST;
`ifdef PE_ARB_STATS_EN
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
              if (pick_idx == ID_W'(i))
                stat_grants[i*CNT_W +: CNT_W] <= stat_grants[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
`endif
          end
        end
        BURST: begin
          if (can_load) begin
            if (sel_valid) begin
              out_data  <= sel_data;
              out_last  <= beat_last;
              out_valid <= 1'b1;
              cnt       <= cnt + BC_W'(1);
              if (beat_last) begin
                ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              // Grantee stalled upstream: emit a bubble but keep the grant.
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
